// File: rtl/spi_chain_link.sv
// rtl/spi_chain_link.sv - continuous 595-chain serial link with readback compare
module spi_chain_link #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 18,
  parameter int GAP     = 8
) (
  input  logic             clk_i,
  input  logic             aclr_n_i,
  input  logic             sclr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_old_o,
  output logic             mismatch_o,
  output logic             frame_done_o,
  output logic             sclk_o,
  output logic             sdo_o,
  output logic             lock_o,
  input  logic             sdi_i
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // One counter serves as the half-period divider and as the idle gap timer.
  localparam int CMAX = (GAP > CLK_DIV) ? GAP : CLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(WIDTH);
  localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);
  localparam logic [1:0]    AFTER_LATCH = (GAP > 0) ? S_GAP : S_LOAD;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] cur_sent_q, cur_sent_d;
  logic [WIDTH-1:0] prev_sent_q, prev_sent_d;
  logic [WIDTH-1:0] data_old_q, data_old_d;
  logic             mismatch_q, mismatch_d;
  logic             frame_done_q, frame_done_d;
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;
  logic             lock_q, lock_d;
  logic             tick;

  assign tick = (cnt_q == DIV_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    cur_sent_d   = cur_sent_q;
    prev_sent_d  = prev_sent_q;
    data_old_d   = data_old_q;
    mismatch_d   = mismatch_q;
    frame_done_d = 1'b0;
    sclk_d       = sclk_q;
    sdo_d        = sdo_q;
    lock_d       = lock_q;
    case (state_q)
      S_LOAD: begin
        tx_sr_d    = data_i;
        cur_sent_d = data_i;
        sdo_d      = data_i[WIDTH-1];
        sclk_d     = 1'b0;
        lock_d     = 1'b0;
        cnt_d      = '0;
        bit_d      = '0;
        phase_d    = 1'b0;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick && !phase_q) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[WIDTH-2:0], sdi_i};
          phase_d = 1'b1;
        end else if (tick) begin
          // Data moves on the falling edge so it is settled a full half-period before the next rise.
          sclk_d  = 1'b0;
          tx_sr_d = tx_sr_q << 1;
          sdo_d   = tx_sr_q[WIDTH-2];
          phase_d = 1'b0;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            sdo_d   = 1'b0;
            lock_d  = 1'b1;
            bit_d   = '0;
            state_d = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick && !phase_q) begin
          lock_d  = 1'b0;
          phase_d = 1'b1;
        end else if (tick) begin
          data_old_d   = rx_sr_q;
          mismatch_d   = (rx_sr_q != prev_sent_q);
          prev_sent_d  = cur_sent_q;
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
          state_d      = AFTER_LATCH;
        end
      end
      default: begin
        sclk_d = 1'b0;
        lock_d = 1'b0;
        sdo_d  = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    if (sclr_i) begin
      state_d      = S_LOAD;
      cnt_d        = '0;
      bit_d        = '0;
      phase_d      = 1'b0;
      prev_sent_d  = '0;
      data_old_d   = '0;
      mismatch_d   = 1'b0;
      frame_done_d = 1'b0;
      sclk_d       = 1'b0;
      sdo_d        = 1'b0;
      lock_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      bit_q        <= '0;
      phase_q      <= 1'b0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      cur_sent_q   <= '0;
      prev_sent_q  <= '0;
      data_old_q   <= '0;
      mismatch_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sclk_q       <= 1'b0;
      sdo_q        <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      cur_sent_q   <= cur_sent_d;
      prev_sent_q  <= prev_sent_d;
      data_old_q   <= data_old_d;
      mismatch_q   <= mismatch_d;
      frame_done_q <= frame_done_d;
      sclk_q       <= sclk_d;
      sdo_q        <= sdo_d;
      lock_q       <= lock_d;
    end
  end

  assign data_old_o   = data_old_q;
  assign mismatch_o   = mismatch_q;
  assign frame_done_o = frame_done_q;
  assign sclk_o       = sclk_q;
  assign sdo_o        = sdo_q;
  assign lock_o       = lock_q;

endmodule

// File: tb/tb_spi_chain_link.sv
// tb/tb_spi_chain_link.sv - directed bench for spi_chain_link with a 16-bit 595 chain model
module tb_spi_chain_link;

  logic        clk = 1'b0;
  logic        aclr_n = 1'b0;
  logic        sclr = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [15:0] data_old;
  logic        mismatch, frame_done, sclk, sdo, lock, sdi;

  int tests = 0;
  int fails = 0;

  logic [15:0] chain;
  logic        chain_clr = 1'b1;
  logic        stuck = 1'b0;
  logic [15:0] cap;
  int          rises;
  logic        cap_clr = 1'b1;

  always #5 clk = ~clk;

  spi_chain_link #(.WIDTH(16), .CLK_DIV(2), .GAP(4)) dut (
    .clk_i(clk), .aclr_n_i(aclr_n), .sclr_i(sclr), .data_i(data),
    .data_old_o(data_old), .mismatch_o(mismatch), .frame_done_o(frame_done),
    .sclk_o(sclk), .sdo_o(sdo), .lock_o(lock), .sdi_i(sdi)
  );

  // 595 shift stage: QH' presents the bit that is about to fall out of the chain
  assign sdi = stuck ? 1'b1 : chain[15];
  always @(posedge sclk or posedge chain_clr)
    if (chain_clr) chain <= 16'h0000;
    else           chain <= {chain[14:0], sdo};

  always @(posedge sclk or posedge cap_clr)
    if (cap_clr) begin cap <= 16'h0000; rises <= 0; end
    else begin cap <= {cap[14:0], sdo}; rises <= rises + 1; end

  task automatic do_reset(input logic [15:0] d);
    data = d; stuck = 1'b0; sclr = 1'b0; aclr_n = 1'b0;
    chain_clr = 1'b1; cap_clr = 1'b1;
    repeat (2) @(negedge clk);
    chain_clr = 1'b0; cap_clr = 1'b0; aclr_n = 1'b1;
  endtask

  task automatic next_frame(output bit ok, output logic [15:0] sent, output int nr);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
    sent = cap; nr = rises;
    cap_clr = 1'b1; #1 cap_clr = 1'b0;
  endtask

  task automatic test_reset();
    data = 16'hA55A; aclr_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({data_old, mismatch, frame_done, sclk, sdo, lock} !== 21'h0) begin
      fails++;
      $display("FAIL reset_outputs got data_old=%h mm=%b fd=%b sclk=%b sdo=%b lock=%b want all 0",
               data_old, mismatch, frame_done, sclk, sdo, lock);
    end
  endtask

  task automatic test_basic();
    bit ok; logic [15:0] s; int nr;
    do_reset(16'hA55A);
    next_frame(ok, s, nr);
    tests++;
    if (!ok || data_old !== 16'h0000 || mismatch !== 1'b0 || s !== 16'hA55A || nr !== 16) begin
      fails++;
      $display("FAIL basic_f1 ok=%b data_old=%h mm=%b sent=%h rises=%0d want 0000 0 A55A 16", ok, data_old, mismatch, s, nr);
    end
    next_frame(ok, s, nr);
    tests++;
    if (!ok || data_old !== 16'hA55A || mismatch !== 1'b0 || s !== 16'hA55A || nr !== 16) begin
      fails++;
      $display("FAIL basic_f2 ok=%b data_old=%h mm=%b sent=%h rises=%0d want A55A 0 A55A 16", ok, data_old, mismatch, s, nr);
    end
  endtask

  task automatic test_data_change();
    bit ok; logic [15:0] s; int nr;
    logic [15:0] exp_old [4] = '{16'h0000, 16'h1234, 16'h1234, 16'hFFFF};
    logic [15:0] exp_snt [4] = '{16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF};
    do_reset(16'h1234);
    for (int f = 0; f < 4; f++) begin
      next_frame(ok, s, nr);
      tests++;
      if (!ok || data_old !== exp_old[f] || mismatch !== 1'b0 || s !== exp_snt[f]) begin
        fails++;
        $display("FAIL data_change_f%0d ok=%b data_old=%h mm=%b sent=%h want %h 0 %h",
                 f + 1, ok, data_old, mismatch, s, exp_old[f], exp_snt[f]);
      end
      if (f == 0) begin
        repeat (10) @(negedge clk);
        data = 16'hFFFF;
      end
    end
  endtask

  task automatic test_stuck();
    bit ok; logic [15:0] s; int nr;
    logic [15:0] exp_old [4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    logic        exp_mm  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset(16'h0000);
    stuck = 1'b1;
    for (int f = 0; f < 4; f++) begin
      next_frame(ok, s, nr);
      tests++;
      if (!ok || data_old !== exp_old[f] || mismatch !== exp_mm[f]) begin
        fails++;
        $display("FAIL stuck_f%0d ok=%b data_old=%h mm=%b want %h %b", f + 1, ok, data_old, mismatch, exp_old[f], exp_mm[f]);
      end
      if (f == 1) stuck = 1'b0;
    end
  endtask

  task automatic test_sclr();
    bit ok; logic [15:0] s; int nr; int seen;
    do_reset(16'hA55A);
    next_frame(ok, s, nr);
    next_frame(ok, s, nr);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rises == 7) begin ok = 1'b1; break; end
    end
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    tests++;
    if (!ok || sclk !== 1'b0 || lock !== 1'b0 || sdo !== 1'b0 || data_old !== 16'h0000 || mismatch !== 1'b0) begin
      fails++;
      $display("FAIL sclr_idle ok=%b sclk=%b lock=%b sdo=%b data_old=%h mm=%b want 1 0 0 0 0000 0",
               ok, sclk, lock, sdo, data_old, mismatch);
    end
    cap_clr = 1'b1; #1 cap_clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_done) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL sclr_no_done got %0d frame_done pulses want 0", seen);
    end
    // chain held A55A and took 7 more bits of A55A before the abort: rotate-left-7 = AD52
    next_frame(ok, s, nr);
    tests++;
    if (!ok || data_old !== 16'hAD52 || mismatch !== 1'b1 || s !== 16'hA55A || nr !== 16) begin
      fails++;
      $display("FAIL sclr_restart ok=%b data_old=%h mm=%b sent=%h rises=%0d want AD52 1 A55A 16", ok, data_old, mismatch, s, nr);
    end
  endtask

  task automatic test_aclr();
    bit ok; logic [15:0] s; int nr;
    do_reset(16'h1234);
    next_frame(ok, s, nr);
    next_frame(ok, s, nr);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lock) begin ok = 1'b1; break; end
    end
    #2 aclr_n = 1'b0;
    #1;
    tests++;
    if (!ok || {data_old, mismatch, frame_done, sclk, sdo, lock} !== 21'h0) begin
      fails++;
      $display("FAIL aclr_async ok=%b data_old=%h mm=%b fd=%b sclk=%b sdo=%b lock=%b want all 0",
               ok, data_old, mismatch, frame_done, sclk, sdo, lock);
    end
    repeat (2) @(negedge clk);
    cap_clr = 1'b1; #1 cap_clr = 1'b0;
    aclr_n = 1'b1;
    next_frame(ok, s, nr);
    tests++;
    if (!ok || data_old !== 16'h1234 || mismatch !== 1'b1 || s !== 16'h1234 || nr !== 16) begin
      fails++;
      $display("FAIL aclr_restart ok=%b data_old=%h mm=%b sent=%h rises=%0d want 1234 1 1234 16", ok, data_old, mismatch, s, nr);
    end
  endtask

  task automatic test_timing();
    bit ok; logic [15:0] s; int nr;
    int n, run, bad, viol, lock_hi; logic prev; bit seen_high;
    do_reset(16'hA55A);
    next_frame(ok, s, nr);
    n = 0; run = 0; bad = 0; viol = 0; lock_hi = 0; prev = sclk; seen_high = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (lock && sclk) viol++;
      if (lock) lock_hi++;
      if (sclk == prev) run++;
      else begin
        if (prev && run != 2) bad++;
        if (!prev && seen_high && run != 2) bad++;
        if (prev) seen_high = 1'b1;
        prev = sclk; run = 1;
      end
      if (frame_done) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok || n != 73) begin
      fails++;
      $display("FAIL timing_period ok=%b got %0d clks want 73", ok, n);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL timing_sclk_width got %0d bad half-periods want 0", bad);
    end
    tests++;
    if (rises !== 16) begin
      fails++;
      $display("FAIL timing_rises got %0d want 16", rises);
    end
    tests++;
    if (viol != 0 || lock_hi != 2) begin
      fails++;
      $display("FAIL timing_lock got overlap=%0d high_clks=%0d want 0 2", viol, lock_hi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_data_change();
    test_stuck();
    test_sclr();
    test_aclr();
    test_timing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
